// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider.
// Output mode encoding and the default counter width.
package clk_div_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int CW_DEFAULT = 27;

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi: per-channel enables, modes and limits in,
// divided clocks and terminal-count strobes out.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = CW_DEFAULT
) ();

  logic [NCH-1:0]    en;
  logic [NCH-1:0]    mode;
  logic [NCH*CW-1:0] limit;
  logic              sync_clr;
  logic [NCH-1:0]    div_out;
  logic [NCH-1:0]    tick;

  modport master (
    output en, mode, limit, sync_clr,
    input  div_out, tick
  );

  modport slave (
    input  en, mode, limit, sync_clr,
    output div_out, tick
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counts to a shadowed limit, emits tick and toggle/pulse output.
// Outputs registered, one edge after the terminal-count cycle; no backpressure.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic [CW-1:0] limit,
  input  logic          sync_clr,
  output logic          div_out,
  output logic          tick
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic          armed_q, armed_d;
  logic          div_out_q, div_out_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    armed_d   = armed_q;
    div_out_d = div_out_q;
    tick_d    = 1'b0;
    if (sync_clr) begin
      cnt_d     = '0;
      shadow_d  = limit;
      armed_d   = 1'b1;
      div_out_d = 1'b0;
    end else if (!en) begin
      shadow_d = limit;
      if (mode == MODE_PULSE) div_out_d = 1'b0;
    end else if (!armed_q) begin
      shadow_d = limit;
      armed_d  = 1'b1;
    end else if (cnt_q >= shadow_q) begin
      // ">=" so a held count above a freshly lowered limit ends the period at once
      cnt_d     = '0;
      shadow_d  = limit;
      tick_d    = 1'b1;
      div_out_d = (mode == MODE_PULSE) ? 1'b1 : ~div_out_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (mode == MODE_PULSE) div_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      shadow_q  <= '0;
      armed_q   <= 1'b0;
      div_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      armed_q   <= armed_d;
      div_out_q <= div_out_d;
      tick_q    <= tick_d;
    end
  end

  assign div_out = div_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent programmable clock-enable/divider channels sharing clk, rst and sync_clr.
// Outputs registered in each channel; no backpressure.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = CW_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  clk_div_multi_if.slave bus
);

  logic [NCH-1:0] div_out_w;
  logic [NCH-1:0] tick_w;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_div_chan #(.CW(CW)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en[i]),
      .mode     (bus.mode[i]),
      .limit    (bus.limit[i*CW +: CW]),
      .sync_clr (bus.sync_clr),
      .div_out  (div_out_w[i]),
      .tick     (tick_w[i])
    );
  end

  assign bus.div_out = div_out_w;
  assign bus.tick    = tick_w;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed vector table, hand sequences for period corners,
// then random stimulus against a rule-level reference model.
module tb_clk_div_multi;
  localparam int NCH = 2;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  clk_div_multi_if #(.NCH(NCH), .CW(CW)) bus ();

  clk_div_multi #(.NCH(NCH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] en;
    logic [1:0] div;
    logic [1:0] tick;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ch0 toggle limit 3, ch1 pulse limit 0; row c = outputs seen during cycle c
  task automatic init_table();
    tbl[0]  = '{2'b11, 2'b00, 2'b00};
    tbl[1]  = '{2'b11, 2'b00, 2'b00};
    tbl[2]  = '{2'b11, 2'b10, 2'b10};
    tbl[3]  = '{2'b11, 2'b10, 2'b10};
    tbl[4]  = '{2'b11, 2'b10, 2'b10};
    tbl[5]  = '{2'b11, 2'b11, 2'b11};
    tbl[6]  = '{2'b11, 2'b11, 2'b10};
    tbl[7]  = '{2'b11, 2'b11, 2'b10};
    tbl[8]  = '{2'b11, 2'b11, 2'b10};
    tbl[9]  = '{2'b11, 2'b10, 2'b11};
    tbl[10] = '{2'b11, 2'b10, 2'b10};
    tbl[11] = '{2'b11, 2'b10, 2'b10};
    tbl[12] = '{2'b11, 2'b10, 2'b10};
    tbl[13] = '{2'b11, 2'b11, 2'b11};
    tbl[14] = '{2'b01, 2'b11, 2'b10};
    tbl[15] = '{2'b01, 2'b01, 2'b00};
  endtask

  task automatic set_t1_inputs();
    bus.en       = 2'b11;
    bus.mode     = 2'b10;
    bus.limit    = {8'd0, 8'd3};
    bus.sync_clr = 1'b0;
  endtask

  task automatic run_table(input string tag);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) step();
      bus.en = tbl[c].en;
      check($sformatf("%s_div_c%0d", tag, c), 32'(bus.div_out), 32'(tbl[c].div));
      check($sformatf("%s_tick_c%0d", tag, c), 32'(bus.tick), 32'(tbl[c].tick));
    end
  endtask

  // Reference model: each channel is described by elapsed count within its period
  int   m_cnt[NCH];
  int   m_per[NCH];
  logic m_arm[NCH];
  logic m_div[NCH];
  logic m_tick[NCH];

  function automatic int lim_of(input int i);
    return int'(bus.limit[i*CW +: CW]);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] <= 0; m_per[i] <= 0; m_arm[i] <= 1'b0; m_div[i] <= 1'b0; m_tick[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.sync_clr) begin
          m_cnt[i] <= 0; m_per[i] <= lim_of(i); m_arm[i] <= 1'b1; m_div[i] <= 1'b0; m_tick[i] <= 1'b0;
        end else if (!bus.en[i]) begin
          m_per[i] <= lim_of(i); m_tick[i] <= 1'b0;
          if (bus.mode[i]) m_div[i] <= 1'b0;
        end else if (!m_arm[i]) begin
          m_per[i] <= lim_of(i); m_arm[i] <= 1'b1; m_tick[i] <= 1'b0;
        end else if (m_cnt[i] >= m_per[i]) begin
          m_cnt[i] <= 0; m_per[i] <= lim_of(i); m_tick[i] <= 1'b1;
          m_div[i] <= bus.mode[i] ? 1'b1 : !m_div[i];
        end else begin
          m_cnt[i] <= m_cnt[i] + 1; m_tick[i] <= 1'b0;
          if (bus.mode[i]) m_div[i] <= 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] mask0, mask1;
    init_table();
    bus.en = '0; bus.mode = '0; bus.limit = '0; bus.sync_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_div", 32'(bus.div_out), 32'h0);
    check("reset_tick", 32'(bus.tick), 32'h0);

    // Test 1/2: basic toggle period and pulse limit=0, then ch1 disabled
    set_t1_inputs();
    @(negedge clk);
    rst = 1'b1;
    run_table("t1");

    // Test 3: limit lowered mid-period only applies after current period
    bus.en = 2'b11; bus.mode = 2'b10; bus.limit = {8'd0, 8'd9}; bus.sync_clr = 1'b1;
    step();
    bus.sync_clr = 1'b0;
    check("t3_clr_div", 32'(bus.div_out), 32'h0);
    check("t3_clr_tick", 32'(bus.tick), 32'h0);
    mask0 = '0;
    for (int k = 0; k < 18; k++) begin
      if (k == 4) bus.limit[7:0] = 8'd2;
      mask0[k] = bus.tick[0];
      step();
    end
    check("t3_tick_positions", mask0, 32'h0001_2400);

    // Test 4: disable at cnt=7, lower limit, re-enable -> immediate terminal
    bus.limit = {8'd0, 8'd9}; bus.sync_clr = 1'b1;
    step();
    bus.sync_clr = 1'b0;
    mask0 = '0;
    for (int k = 0; k < 20; k++) begin
      if (k == 7) begin bus.en[0] = 1'b0; bus.limit[7:0] = 8'd3; end
      if (k == 9) bus.en[0] = 1'b1;
      if (k == 12) check("t4_div_k12", 32'(bus.div_out[0]), 32'h1);
      mask0[k] = bus.tick[0];
      step();
    end
    check("t4_tick_positions", mask0, 32'h0004_4400);

    // Test 5: skew phases, then sync_clr realigns equal-limit channels
    bus.mode = 2'b00; bus.limit = {8'd5, 8'd5}; bus.en = 2'b01;
    repeat (3) step();
    bus.en = 2'b11;
    repeat (2) step();
    bus.sync_clr = 1'b1;
    step();
    bus.sync_clr = 1'b0;
    check("t5_clr_div", 32'(bus.div_out), 32'h0);
    check("t5_clr_tick", 32'(bus.tick), 32'h0);
    mask0 = '0; mask1 = '0;
    for (int k = 0; k < 14; k++) begin
      if (k == 7) check("t5_div_k7", 32'(bus.div_out), 32'h3);
      mask0[k] = bus.tick[0];
      mask1[k] = bus.tick[1];
      step();
    end
    check("t5_ch0_ticks", mask0, 32'h0000_1040);
    check("t5_ch1_ticks", mask1, 32'h0000_1040);

    // Test 6: short async reset pulse between edges, then test 1 repeats
    set_t1_inputs();
    repeat (8) step();
    check("t6_pre_div1", 32'(bus.div_out[1]), 32'h1);
    #1 rst = 1'b0;
    #1;
    check("t6_async_div", 32'(bus.div_out), 32'h0);
    check("t6_async_tick", 32'(bus.tick), 32'h0);
    #1 rst = 1'b1;
    run_table("t6");

    // Random stimulus against the reference model
    for (int r = 0; r < 1500; r++) begin
      for (int i = 0; i < NCH; i++) begin
        bus.en[i] = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 15) == 0) bus.mode[i] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) bus.limit[i*CW +: CW] = 8'($urandom_range(0, 12));
      end
      bus.sync_clr = ($urandom_range(0, 63) == 0);
      step();
      check($sformatf("rnd%0d_div", r), 32'(bus.div_out), 32'({m_div[1], m_div[0]}));
      check($sformatf("rnd%0d_tick", r), 32'(bus.tick), 32'({m_tick[1], m_tick[0]}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
